// File: rtl/pe_array_seq_ctrl_pkg.sv
// Shared constants and types for the PE array sequencer.
// Optional output ReLU is selected with PE_SEQ_CTRL_RELU_EN.
package pe_pkg;
  localparam int PE_H         = 8;
  localparam int PE_W         = 8;
  localparam int BIT          = 8;
  localparam int ACC_W        = 4 * BIT;
  localparam int MAX_INFLIGHT = 8;
  localparam int CNT_W        = 16;
  localparam int INF_W        = $clog2(MAX_INFLIGHT + 1);

  typedef logic [PE_W-1:0][BIT-1:0]      ifmap_vec_t;
  typedef logic [PE_H*PE_W-1:0][BIT-1:0] weight_vec_t;
  typedef logic [PE_H-1:0][ACC_W-1:0]    psum_vec_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } seq_state_t;
endpackage

// File: rtl/pe_array_seq_ctrl_if.sv
// Job, operand, array and result bundle of the PE array sequencer.
// The slave view is the sequencer; the master view is its environment.
interface pe_array_seq_ctrl_if;
  import pe_pkg::*;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_chunks;
  psum_vec_t        cfg_bias;
  logic             in_valid;
  logic             in_ready;
  ifmap_vec_t       in_ifmap;
  weight_vec_t      in_weight;
  logic             pe_en;
  ifmap_vec_t       pe_ifmap;
  weight_vec_t      pe_weight;
  psum_vec_t        pe_bias;
  psum_vec_t        pe_ofmap;
  logic             pe_valid;
  logic             out_valid;
  logic             out_ready;
  psum_vec_t        out_data;
  logic             busy;
  logic             err;

  modport slave (
    input  cfg_valid, cfg_chunks, cfg_bias,
    input  in_valid, in_ifmap, in_weight,
    input  pe_ofmap, pe_valid, out_ready,
    output cfg_ready, in_ready,
    output pe_en, pe_ifmap, pe_weight, pe_bias,
    output out_valid, out_data, busy, err
  );

  modport master (
    output cfg_valid, cfg_chunks, cfg_bias,
    output in_valid, in_ifmap, in_weight,
    output pe_ofmap, pe_valid, out_ready,
    input  cfg_ready, in_ready,
    input  pe_en, pe_ifmap, pe_weight, pe_bias,
    input  out_valid, out_data, busy, err
  );
endinterface

// File: rtl/pe_array_seq_ctrl_psum_accum.sv
// Per-lane partial-sum accumulator: bias load, wrapping add, output mux.
// PE_SEQ_CTRL_RELU_EN clamps negative lanes to zero on the output.
module pe_psum_accum
  import pe_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      load_i,
  input  psum_vec_t bias_i,
  input  logic      add_i,
  input  psum_vec_t psum_i,
  output psum_vec_t data_o
);
  psum_vec_t acc_q;
  psum_vec_t acc_d;

  always_comb begin
    acc_d = acc_q;
    if (load_i) begin
      acc_d = bias_i;
    end else if (add_i) begin
      for (int i = 0; i < PE_H; i++) begin
        acc_d[i] = acc_q[i] + psum_i[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  always_comb begin
    data_o = acc_q;
`ifdef PE_SEQ_CTRL_RELU_EN
    for (int i = 0; i < PE_H; i++) begin
      if (acc_q[i][ACC_W-1]) data_o[i] = '0;
    end
`endif
  end
endmodule

// File: rtl/pe_array_seq_ctrl.sv
// Sequences one output-channel group through the PE array with credits.
// Output ReLU (PE_SEQ_CTRL_RELU_EN) lives in pe_psum_accum.
module pe_array_seq_ctrl
  import pe_pkg::*;
(
  input logic               clk,
  input logic               rst,
  pe_array_seq_ctrl_if.slave bus
);
  seq_state_t       state_q;
  logic [CNT_W-1:0] chunks_q;
  logic [CNT_W-1:0] issued_q;
  logic [CNT_W-1:0] returned_q;
  logic [CNT_W-1:0] returned_d;
  logic [INF_W-1:0] inflight_q;
  logic             pe_en_q;
  logic             err_q;
  ifmap_vec_t       ifmap_q;
  weight_vec_t      weight_q;
  logic             accept;
  logic             ret;
  logic             load;

  assign bus.in_ready = (state_q == ISSUE)
                     && (issued_q < chunks_q)
                     && (inflight_q < INF_W'(MAX_INFLIGHT));
  assign accept = bus.in_valid && bus.in_ready;
  // Returns only count while a chunk is actually outstanding
  assign ret = bus.pe_valid
            && (state_q == ISSUE || state_q == DRAIN)
            && (inflight_q != '0);
  assign load = (state_q == IDLE) && bus.cfg_valid;
  assign returned_d = returned_q + CNT_W'(ret);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      chunks_q   <= '0;
      issued_q   <= '0;
      returned_q <= '0;
      inflight_q <= '0;
      pe_en_q    <= 1'b0;
      err_q      <= 1'b0;
      ifmap_q    <= '0;
      weight_q   <= '0;
    end else begin
      pe_en_q    <= accept;
      issued_q   <= issued_q + CNT_W'(accept);
      returned_q <= returned_d;
      if (accept) begin
        ifmap_q  <= bus.in_ifmap;
        weight_q <= bus.in_weight;
      end
      if (bus.pe_valid && !ret) err_q <= 1'b1;
      unique case ({accept, ret})
        2'b10:   inflight_q <= inflight_q + INF_W'(1);
        2'b01:   inflight_q <= inflight_q - INF_W'(1);
        default: inflight_q <= inflight_q;
      endcase
      unique case (state_q)
        IDLE: if (bus.cfg_valid) begin
          chunks_q   <= bus.cfg_chunks;
          issued_q   <= '0;
          returned_q <= '0;
          inflight_q <= '0;
          state_q    <= (bus.cfg_chunks == '0) ? DONE : ISSUE;
        end
        ISSUE: if (accept && (issued_q + CNT_W'(1) == chunks_q))
          state_q <= DRAIN;
        DRAIN: if (returned_d == chunks_q)
          state_q <= DONE;
        DONE: if (bus.out_ready)
          state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  pe_psum_accum u_accum (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .bias_i (bus.cfg_bias),
    .add_i  (ret),
    .psum_i (bus.pe_ofmap),
    .data_o (bus.out_data)
  );

  assign bus.cfg_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.pe_en     = pe_en_q;
  assign bus.pe_ifmap  = ifmap_q;
  assign bus.pe_weight = weight_q;
  assign bus.pe_bias   = '0;
  assign bus.err       = err_q;
endmodule
